// File: rtl/sram_arb_ctrl.sv
// Two-port (fetch / data) controller for an external asynchronous SRAM.
// Round-robin arbitration, SETUP/STROBE/HOLD access timing, registered pad outputs.
module sram_arb_ctrl #(
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_we,
  output logic              sram_oe,
  output logic [DATA_W-1:0] sram_dout,
  output logic              sram_dout_en,
  input  logic [DATA_W-1:0] sram_din
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  localparam logic       G_FETCH = 1'b0;
  localparam logic       G_DATA  = 1'b1;
  localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

  state_t            state, state_nxt;
  logic              last_grant, last_nxt;
  logic              gnt_d, gnt_nxt;
  logic              lat_we, lat_we_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              sel_d;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] dout_nxt;
  logic              we_nxt, oe_nxt, dout_en_nxt;
  logic              f_ack_nxt, d_ack_nxt, f_cap, d_cap;

  // Next-state and next-output decode; every pad/handshake output is the
  // registered version of these so nothing combinational reaches the pins.
  always_comb begin
    state_nxt   = state;
    last_nxt    = last_grant;
    gnt_nxt     = gnt_d;
    lat_we_nxt  = lat_we;
    cnt_nxt     = cnt;
    addr_nxt    = sram_addr;
    dout_nxt    = sram_dout;
    we_nxt      = 1'b0;
    oe_nxt      = 1'b0;
    dout_en_nxt = 1'b0;
    f_ack_nxt   = 1'b0;
    d_ack_nxt   = 1'b0;
    f_cap       = 1'b0;
    d_cap       = 1'b0;
    // On a tie the port that did not win last time takes the grant.
    sel_d       = d_req && (!f_req || (last_grant == G_FETCH));
    case (state)
      IDLE: begin
        if (f_req || d_req) begin
          state_nxt  = SETUP;
          gnt_nxt    = sel_d;
          last_nxt   = sel_d ? G_DATA : G_FETCH;
          lat_we_nxt = sel_d && d_we;
          addr_nxt   = sel_d ? d_addr : f_addr;
          if (sel_d && d_we) begin
            dout_nxt    = d_wdata;
            dout_en_nxt = 1'b1;
          end
        end
      end
      SETUP: begin
        state_nxt   = STROBE;
        cnt_nxt     = WS_LOAD;
        dout_en_nxt = lat_we;
        we_nxt      = lat_we;
        oe_nxt      = !lat_we;
      end
      STROBE: begin
        dout_en_nxt = lat_we;
        if (cnt == 4'd0) begin
          state_nxt = HOLD;
          f_ack_nxt = !gnt_d;
          d_ack_nxt = gnt_d;
          f_cap     = !gnt_d;
          d_cap     = gnt_d && !lat_we;
        end else begin
          cnt_nxt = cnt - 4'd1;
          we_nxt  = lat_we;
          oe_nxt  = !lat_we;
        end
      end
      HOLD: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Control state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= G_FETCH;
      gnt_d      <= 1'b0;
      lat_we     <= 1'b0;
      cnt        <= 4'd0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_nxt;
      gnt_d      <= gnt_nxt;
      lat_we     <= lat_we_nxt;
      cnt        <= cnt_nxt;
    end
  end

  // Registered outputs; the address and write-data pads double as the
  // request latches, so they only change on a grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy         <= 1'b0;
      sram_addr    <= '0;
      sram_dout    <= '0;
      sram_we      <= 1'b0;
      sram_oe      <= 1'b0;
      sram_dout_en <= 1'b0;
      f_ack        <= 1'b0;
      d_ack        <= 1'b0;
      f_rdata      <= '0;
      d_rdata      <= '0;
    end else begin
      busy         <= (state_nxt != IDLE);
      sram_addr    <= addr_nxt;
      sram_dout    <= dout_nxt;
      sram_we      <= we_nxt;
      sram_oe      <= oe_nxt;
      sram_dout_en <= dout_en_nxt;
      f_ack        <= f_ack_nxt;
      d_ack        <= d_ack_nxt;
      if (f_cap) f_rdata <= sram_din;
      if (d_cap) d_rdata <= sram_din;
    end
  end

endmodule

// File: tb/tb_sram_arb_ctrl.sv
// Scoreboard bench for sram_arb_ctrl: a zero-wait-state instance with an SRAM
// model, plus a three-wait-state instance for strobe-length checks.
module tb_sram_arb_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        f_req, f_ack, d_req, d_we, d_ack, busy;
  logic [17:0] f_addr, d_addr, sram_addr;
  logic [15:0] f_rdata, d_wdata, d_rdata, sram_dout, sram_din;
  logic        sram_we, sram_oe, sram_dout_en;

  logic        w3_f_req, w3_f_ack, w3_d_req, w3_d_we, w3_d_ack, w3_busy;
  logic [7:0]  w3_f_addr, w3_d_addr, w3_sram_addr;
  logic [15:0] w3_f_rdata, w3_d_wdata, w3_d_rdata, w3_sram_dout, w3_sram_din;
  logic        w3_sram_we, w3_sram_oe, w3_sram_dout_en;

  sram_arb_ctrl #(.ADDR_W(18), .DATA_W(16), .WAIT_STATES(0)) u_dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .busy(busy),
    .sram_addr(sram_addr), .sram_we(sram_we), .sram_oe(sram_oe),
    .sram_dout(sram_dout), .sram_dout_en(sram_dout_en), .sram_din(sram_din)
  );

  sram_arb_ctrl #(.ADDR_W(8), .DATA_W(16), .WAIT_STATES(3)) u_dut_ws3 (
    .clk(clk), .rst(rst),
    .f_req(w3_f_req), .f_addr(w3_f_addr), .f_ack(w3_f_ack), .f_rdata(w3_f_rdata),
    .d_req(w3_d_req), .d_we(w3_d_we), .d_addr(w3_d_addr), .d_wdata(w3_d_wdata),
    .d_ack(w3_d_ack), .d_rdata(w3_d_rdata), .busy(w3_busy),
    .sram_addr(w3_sram_addr), .sram_we(w3_sram_we), .sram_oe(w3_sram_oe),
    .sram_dout(w3_sram_dout), .sram_dout_en(w3_sram_dout_en), .sram_din(w3_sram_din)
  );

  // SRAM models
  logic [15:0] mem [0:262143];
  logic        pre_en;
  logic [17:0] pre_addr;
  logic [15:0] pre_data;
  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (sram_we) mem[sram_addr] <= sram_dout;
  end
  assign sram_din    = sram_oe ? mem[sram_addr] : 16'h0000;
  assign w3_sram_din = (w3_sram_oe && (w3_sram_addr == 8'h3C)) ? 16'hA5A5 : 16'h0000;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    bit          is_d;
    logic [15:0] exp_f;
    logic [15:0] exp_d;
    int          exp_cyc;
  } sb_t;
  sb_t sb_q[$];

  logic [15:0] shadow [logic [17:0]];
  logic [15:0] exp_f = 16'h0;
  logic [15:0] exp_d = 16'h0;

  int          cyc = 0;
  int          oe_cycles = 0;
  int          we_cycles = 0;
  logic [17:0] oe_addr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: pops one expectation per ack
  always @(posedge clk) begin
    sb_t e;
    #1;
    if (sram_oe) begin
      oe_cycles++;
      oe_addr = sram_addr;
    end
    if (sram_we) we_cycles++;
    if (f_ack && d_ack) chk("ack_overlap", 32'(f_ack & d_ack), 32'd0);
    if (sram_we && sram_oe) chk("we_oe_overlap", 32'(sram_we & sram_oe), 32'd0);
    if (f_ack || d_ack) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_ack", 32'({f_ack, d_ack}), 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("ack_port_d", 32'(d_ack), 32'(e.is_d));
        chk("ack_port_f", 32'(f_ack), 32'(!e.is_d));
        chk("ack_cycle", 32'(cyc), 32'(e.exp_cyc));
        chk("f_rdata", 32'(f_rdata), 32'(e.exp_f));
        chk("d_rdata", 32'(d_rdata), 32'(e.exp_d));
      end
    end
  end

  function automatic logic [15:0] rd(input logic [17:0] a);
    return shadow.exists(a) ? shadow[a] : 16'h0000;
  endfunction

  task automatic preload(input logic [17:0] a, input logic [15:0] v);
    @(negedge clk);
    pre_en = 1'b1; pre_addr = a; pre_data = v;
    shadow[a] = v;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic push_exp(input bit is_d, input int exp_cyc);
    sb_t e;
    e.is_d = is_d; e.exp_f = exp_f; e.exp_d = exp_d; e.exp_cyc = exp_cyc;
    sb_q.push_back(e);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      chk("drain_timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
  endtask

  task automatic access(input bit is_d, input bit we, input logic [17:0] a,
                        input logic [15:0] wd);
    @(negedge clk);
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
    end else begin
      f_req = 1'b1; f_addr = a;
    end
    if (is_d && we) shadow[a] = wd;
    else if (is_d) exp_d = rd(a);
    else exp_f = rd(a);
    push_exp(is_d, cyc + 3);
    wait_drain();
    f_req = 1'b0;
    d_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int oe0, we0, base, n_oe, n_ack, ack_at;
    logic [15:0] w3_got;
    f_req = 0; f_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    w3_f_req = 0; w3_f_addr = '0; w3_d_req = 0; w3_d_we = 0; w3_d_addr = '0; w3_d_wdata = '0;
    pre_en = 0; pre_addr = '0; pre_data = '0;

    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_f_ack", 32'(f_ack), 32'd0);
    chk("rst_d_ack", 32'(d_ack), 32'd0);
    chk("rst_f_rdata", 32'(f_rdata), 32'd0);
    chk("rst_d_rdata", 32'(d_rdata), 32'd0);
    chk("rst_sram_addr", 32'(sram_addr), 32'd0);
    chk("rst_sram_we", 32'(sram_we), 32'd0);
    chk("rst_sram_oe", 32'(sram_oe), 32'd0);
    chk("rst_sram_dout", 32'(sram_dout), 32'd0);
    chk("rst_dout_en", 32'(sram_dout_en), 32'd0);
    chk("rst_w3_busy", 32'(w3_busy), 32'd0);
    rst = 1'b0;

    // Write 0xBEEF to 0x10, checking the pins phase by phase
    @(negedge clk);
    d_req = 1; d_we = 1; d_addr = 18'h00010; d_wdata = 16'hBEEF;
    shadow[18'h00010] = 16'hBEEF;
    push_exp(1'b1, cyc + 3);
    oe0 = oe_cycles;
    @(posedge clk); #1;
    chk("setup_busy", 32'(busy), 32'd1);
    chk("setup_addr", 32'(sram_addr), 32'h10);
    chk("setup_dout", 32'(sram_dout), 32'hBEEF);
    chk("setup_dout_en", 32'(sram_dout_en), 32'd1);
    chk("setup_we", 32'(sram_we), 32'd0);
    chk("setup_oe", 32'(sram_oe), 32'd0);
    @(negedge clk);
    d_req = 0;
    @(posedge clk); #1;
    chk("strobe_we", 32'(sram_we), 32'd1);
    chk("strobe_addr", 32'(sram_addr), 32'h10);
    chk("strobe_dout_en", 32'(sram_dout_en), 32'd1);
    @(posedge clk); #1;
    chk("hold_we", 32'(sram_we), 32'd0);
    chk("hold_dout_en", 32'(sram_dout_en), 32'd1);
    chk("hold_d_ack", 32'(d_ack), 32'd1);
    @(posedge clk); #1;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_dout_en", 32'(sram_dout_en), 32'd0);
    chk("write_oe_cycles", 32'(oe_cycles - oe0), 32'd0);
    wait_drain();

    // Fetch from the top address
    preload(18'h3FFFF, 16'h1234);
    oe0 = oe_cycles; we0 = we_cycles;
    access(1'b0, 1'b0, 18'h3FFFF, 16'h0);
    chk("fetch_oe_cycles", 32'(oe_cycles - oe0), 32'd1);
    chk("fetch_we_cycles", 32'(we_cycles - we0), 32'd0);
    chk("fetch_oe_addr", 32'(oe_addr), 32'h3FFFF);

    // Data reads/writes; f_rdata must hold, writes must not touch d_rdata
    preload(18'h00020, 16'h5A5A);
    access(1'b1, 1'b0, 18'h00020, 16'h0);
    access(1'b1, 1'b1, 18'h00020, 16'hC0DE);
    access(1'b1, 1'b0, 18'h00010, 16'h0);
    access(1'b1, 1'b0, 18'h00020, 16'h0);
    access(1'b0, 1'b0, 18'h00010, 16'h0);

    // Inputs changed after grant must not reach the SRAM
    preload(18'h00041, 16'h0000);
    @(negedge clk);
    d_req = 1; d_we = 1; d_addr = 18'h00040; d_wdata = 16'h7777;
    shadow[18'h00040] = 16'h7777;
    push_exp(1'b1, cyc + 3);
    @(negedge clk);
    d_addr = 18'h00041; d_wdata = 16'h1111;
    @(posedge clk); #1;
    chk("late_change_addr", 32'(sram_addr), 32'h40);
    chk("late_change_dout", 32'(sram_dout), 32'h7777);
    wait_drain();
    d_req = 0;
    access(1'b1, 1'b0, 18'h00040, 16'h0);
    access(1'b1, 1'b0, 18'h00041, 16'h0);

    // Asynchronous reset in the middle of a write strobe
    preload(18'h00100, 16'h1111);
    preload(18'h00200, 16'h2222);
    @(negedge clk);
    d_req = 1; d_we = 1; d_addr = 18'h00050; d_wdata = 16'hDEAD;
    @(posedge clk);
    @(posedge clk); #1;
    chk("pre_rst_we", 32'(sram_we), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_we", 32'(sram_we), 32'd0);
    chk("async_rst_dout_en", 32'(sram_dout_en), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_addr", 32'(sram_addr), 32'd0);
    d_req = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_f = 16'h0;
    exp_d = 16'h0;

    // Continuous tie after reset: D, F, D, F at 4-cycle spacing
    @(negedge clk);
    oe0 = oe_cycles;
    f_req = 1; f_addr = 18'h00100;
    d_req = 1; d_we = 0; d_addr = 18'h00200;
    base = cyc;
    exp_d = 16'h2222; push_exp(1'b1, base + 3);
    exp_f = 16'h1111; push_exp(1'b0, base + 7);
    push_exp(1'b1, base + 11);
    push_exp(1'b0, base + 15);
    wait_drain();
    f_req = 0; d_req = 0;
    chk("tie_oe_cycles", 32'(oe_cycles - oe0), 32'd4);

    // Three wait states: 4-cycle strobe, ack 6 cycles after request
    @(negedge clk);
    w3_d_req = 1; w3_d_we = 0; w3_d_addr = 8'h3C;
    n_oe = 0; n_ack = 0; ack_at = -1; w3_got = '0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (i == 1) w3_d_req = 0;
      if (w3_sram_oe) n_oe++;
      if (w3_d_ack || w3_f_ack) begin
        n_ack++;
        if (ack_at < 0) begin
          ack_at = i;
          w3_got = w3_d_rdata;
        end
      end
    end
    chk("ws3_oe_cycles", 32'(n_oe), 32'd4);
    chk("ws3_ack_cycle", 32'(ack_at), 32'd6);
    chk("ws3_ack_count", 32'(n_ack), 32'd1);
    chk("ws3_d_rdata", 32'(w3_got), 32'hA5A5);
    chk("ws3_f_rdata", 32'(w3_f_rdata), 32'd0);
    chk("ws3_busy", 32'(w3_busy), 32'd0);

    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
